// File: rtl/pc_control_unit.sv
// Instruction-sequencing front end: program counter, 16-entry branch-target LUT
// and the main opcode decoder. Only the program counter holds state.
module pc_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  mach_code,
  input  logic        one_q,
  input  logic        rel_jump_en,
  output logic [11:0] prog_ctr,
  output logic [11:0] target,
  output logic [1:0]  inst_type,
  output logic        branch_inst,
  output logic        abs_jump,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic [3:0]  alu_op
);

  localparam int unsigned D = 12;
  localparam int unsigned A = 4;

  logic [3:0] funct;
  assign funct = mach_code[7:4];

  // Branch-target table: entry k holds 10*k.
  always_comb begin
    target = D'(0);
    case (mach_code[3:0])
      4'd0:    target = D'(0);
      4'd1:    target = D'(10);
      4'd2:    target = D'(20);
      4'd3:    target = D'(30);
      4'd4:    target = D'(40);
      4'd5:    target = D'(50);
      4'd6:    target = D'(60);
      4'd7:    target = D'(70);
      4'd8:    target = D'(80);
      4'd9:    target = D'(90);
      4'd10:   target = D'(100);
      4'd11:   target = D'(110);
      4'd12:   target = D'(120);
      4'd13:   target = D'(130);
      4'd14:   target = D'(140);
      4'd15:   target = D'(150);
      default: target = D'(0);
    endcase
  end

  // Main decoder; opcode 10xxx is reserved and decodes as NOP.
  always_comb begin
    inst_type   = 2'b00;
    branch_inst = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    alu_src     = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    alu_op      = A'(0);
    if (mach_code[8]) begin
      if (mach_code[7]) begin
        inst_type = 2'b11;
        reg_write = 1'b1;
        alu_op    = A'(0);
      end
    end else begin
      case (funct)
        4'b0000, 4'b0001, 4'b0010, 4'b0011,
        4'b0100, 4'b0101, 4'b0110, 4'b0111: begin
          alu_op    = funct;
          alu_src   = 1'b1;
          reg_write = 1'b1;
        end
        4'b1000: begin
          alu_op     = 4'b0111;
          alu_src    = 1'b1;
          mem_read   = 1'b1;
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        4'b1001: begin
          alu_op    = 4'b0111;
          alu_src   = 1'b1;
          mem_write = 1'b1;
        end
        4'b1010: branch_inst = 1'b1;
        default: ;
      endcase
    end
  end

  assign abs_jump = branch_inst & one_q;

  // Reset beats absolute jump, which beats relative jump, which beats +1.
  always_ff @(posedge clk) begin
    if (reset)
      prog_ctr <= D'(0);
    else if (abs_jump)
      prog_ctr <= target;
    else if (rel_jump_en)
      prog_ctr <= prog_ctr + target;
    else
      prog_ctr <= prog_ctr + D'(1);
  end

endmodule

// File: tb/tb_pc_control_unit.sv
// Directed bench for pc_control_unit: reset, branches, relative jumps,
// PC wrap, full opcode decode sweep, target table and reset priority.
module tb_pc_control_unit;

  logic        clk;
  logic        reset;
  logic [8:0]  mach_code;
  logic        one_q;
  logic        rel_jump_en;
  logic [11:0] prog_ctr;
  logic [11:0] target;
  logic [1:0]  inst_type;
  logic        branch_inst;
  logic        abs_jump;
  logic        mem_read;
  logic        mem_write;
  logic        alu_src;
  logic        reg_write;
  logic        mem_to_reg;
  logic [3:0]  alu_op;

  int vectors = 0;
  int miscompares = 0;

  pc_control_unit dut (
    .clk         (clk),
    .reset       (reset),
    .mach_code   (mach_code),
    .one_q       (one_q),
    .rel_jump_en (rel_jump_en),
    .prog_ctr    (prog_ctr),
    .target      (target),
    .inst_type   (inst_type),
    .branch_inst (branch_inst),
    .abs_jump    (abs_jump),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .alu_src     (alu_src),
    .reg_write   (reg_write),
    .mem_to_reg  (mem_to_reg),
    .alu_op      (alu_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset for one edge, then free-run n edges with an add instruction.
  task automatic go_to_pc(input int n);
    reset = 1'b1; mach_code = 9'b0_0000_0000; one_q = 1'b0; rel_jump_en = 1'b0;
    step();
    reset = 1'b0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; mach_code = 9'b0_0000_0000; one_q = 1'b0; rel_jump_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (prog_ctr !== 12'd0) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: got %0d expected 0", i, prog_ctr);
      end
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({reg_write, alu_src, alu_op} !== 6'b11_0000) begin
      miscompares++;
      $display("FAIL add_decode: got %b expected 110000", {reg_write, alu_src, alu_op});
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      vectors++;
      if (prog_ctr !== 12'(i)) begin
        miscompares++;
        $display("FAIL free_run[%0d]: got %0d expected %0d", i, prog_ctr, i);
      end
    end
  endtask

  task automatic test_taken_branch();
    go_to_pc(5);
    vectors++;
    if (prog_ctr !== 12'd5) begin
      miscompares++;
      $display("FAIL taken_start_pc: got %0d expected 5", prog_ctr);
    end
    mach_code = 9'b0_1010_0011; one_q = 1'b1;
    #1;
    vectors++;
    if ({abs_jump, branch_inst, reg_write} !== 3'b110) begin
      miscompares++;
      $display("FAIL taken_ctrl: got %b expected 110", {abs_jump, branch_inst, reg_write});
    end
    vectors++;
    if (target !== 12'd30) begin
      miscompares++;
      $display("FAIL taken_target: got %0d expected 30", target);
    end
    step();
    vectors++;
    if (prog_ctr !== 12'd30) begin
      miscompares++;
      $display("FAIL taken_pc: got %0d expected 30", prog_ctr);
    end
  endtask

  task automatic test_untaken_branch();
    go_to_pc(5);
    mach_code = 9'b0_1010_0011; one_q = 1'b0;
    #1;
    vectors++;
    if (abs_jump !== 1'b0) begin
      miscompares++;
      $display("FAIL untaken_abs: got %b expected 0", abs_jump);
    end
    step();
    vectors++;
    if (prog_ctr !== 12'd6) begin
      miscompares++;
      $display("FAIL untaken_pc: got %0d expected 6", prog_ctr);
    end
    rel_jump_en = 1'b1; one_q = 1'b1;
    step();
    vectors++;
    if (prog_ctr !== 12'd30) begin
      miscompares++;
      $display("FAIL abs_over_rel: got %0d expected 30", prog_ctr);
    end
    rel_jump_en = 1'b0;
  endtask

  task automatic test_rel_jump();
    go_to_pc(0);
    mach_code = 9'b0_1010_1010; one_q = 1'b1;
    step();
    vectors++;
    if (prog_ctr !== 12'd100) begin
      miscompares++;
      $display("FAIL rel_start_pc: got %0d expected 100", prog_ctr);
    end
    mach_code = 9'b0_0000_0010; rel_jump_en = 1'b1;
    #1;
    vectors++;
    if (abs_jump !== 1'b0) begin
      miscompares++;
      $display("FAIL nonbranch_abs: got %b expected 0", abs_jump);
    end
    step();
    vectors++;
    if (prog_ctr !== 12'd120) begin
      miscompares++;
      $display("FAIL rel_pc: got %0d expected 120", prog_ctr);
    end
    rel_jump_en = 1'b0;
  endtask

  task automatic test_wrap();
    go_to_pc(4095);
    vectors++;
    if (prog_ctr !== 12'd4095) begin
      miscompares++;
      $display("FAIL wrap_top: got %0d expected 4095", prog_ctr);
    end
    step();
    vectors++;
    if (prog_ctr !== 12'd0) begin
      miscompares++;
      $display("FAIL wrap_zero: got %0d expected 0", prog_ctr);
    end
    // Relative add also wraps: 4095 + 150 = 4245 -> 149
    go_to_pc(4095);
    mach_code = 9'b0_0000_1111; rel_jump_en = 1'b1;
    step();
    vectors++;
    if (prog_ctr !== 12'd149) begin
      miscompares++;
      $display("FAIL rel_wrap: got %0d expected 149", prog_ctr);
    end
    rel_jump_en = 1'b0;
  endtask

  task automatic test_decode_sweep();
    logic [12:0] exp_v;
    logic [12:0] got_v;
    logic [4:0]  op;
    one_q = 1'b1; reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      op = 5'(i);
      mach_code = {op, 4'b0101};
      // {inst_type, branch, abs, mem_read, mem_write, alu_src, reg_write, mem_to_reg, alu_op}
      if (op[4:3] == 2'b11)      exp_v = 13'b11_0_0_0_0_0_1_0_0000;
      else if (op[4])            exp_v = 13'b00_0_0_0_0_0_0_0_0000;
      else if (op[3] == 1'b0)    exp_v = {9'b00_0_0_0_0_1_1_0, op[3:0]};
      else if (op[3:0] == 4'd8)  exp_v = 13'b00_0_0_1_0_1_1_1_0111;
      else if (op[3:0] == 4'd9)  exp_v = 13'b00_0_0_0_1_1_0_0_0111;
      else if (op[3:0] == 4'd10) exp_v = 13'b00_1_1_0_0_0_0_0_0000;
      else                       exp_v = 13'b00_0_0_0_0_0_0_0_0000;
      #1;
      got_v = {inst_type, branch_inst, abs_jump, mem_read, mem_write,
               alu_src, reg_write, mem_to_reg, alu_op};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL decode[%b]: got %b expected %b", op, got_v, exp_v);
      end
    end
  endtask

  task automatic test_target_table();
    for (int k = 0; k < 16; k++) begin
      mach_code = {5'b0_0000, 4'(k)};
      #1;
      vectors++;
      if (target !== 12'(10 * k)) begin
        miscompares++;
        $display("FAIL target[%0d]: got %0d expected %0d", k, target, 10 * k);
      end
    end
  endtask

  task automatic test_mid_reset();
    go_to_pc(7);
    mach_code = 9'b0_1010_0100; one_q = 1'b1; reset = 1'b1;
    step();
    vectors++;
    if (prog_ctr !== 12'd0) begin
      miscompares++;
      $display("FAIL mid_reset: got %0d expected 0", prog_ctr);
    end
    reset = 1'b0;
    step();
    vectors++;
    if (prog_ctr !== 12'd40) begin
      miscompares++;
      $display("FAIL post_reset_branch: got %0d expected 40", prog_ctr);
    end
  endtask

  initial begin
    reset = 1'b1; mach_code = 9'd0; one_q = 1'b0; rel_jump_en = 1'b0;
    #1;
    test_reset();
    test_taken_branch();
    test_untaken_branch();
    test_rel_jump();
    test_wrap();
    test_decode_sweep();
    test_target_table();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
